spike_event_arbiter: RTL and testbench

- Upstream feeder of the synapse array's broadcast spike bus.
- Collects rectified on/off spike events from NUM_CHANNELS independent sources, such as input encoders or neighbouring routers, using a valid/ready handshake per channel.
- Arbitrates the channels round-robin into one event FIFO.
- Drains the FIFO onto the spike_if bus at no more than one event per enabled cycle, where the synapses match on address and on_off.

---
 rtl/spike_pkg.sv | 8 +
 rtl/spike_if.sv | 8 +
 rtl/spike_event_fifo.sv | 37 +++
 rtl/spike_event_arbiter.sv | 77 +++++++
 tb/tb_spike_event_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spike_pkg.sv
// spike_pkg: shared spike event types for the broadcast bus and synapse side
package spike_pkg;
    localparam int ADDR_WIDTH = 8;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic                  on_off;
    } spike_event_t;
endpackage

// File: rtl/spike_if.sv
// spike_if: broadcast spike bus (valid, address, on_off) matched on by synapses
interface spike_if #(parameter int ADDR_WIDTH = spike_pkg::ADDR_WIDTH);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] address;
    logic                  on_off;
    modport master (output valid, address, on_off);
    modport slave (input valid, address, on_off);
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: power-of-two FIFO of spike events with explicit occupancy count
//   clk, reset (async active-low)
//   push/push_data: write one entry; caller guarantees room (or a same-cycle pop)
//   pop/pop_data:   pop_data is the head entry; pop advances past it
//   count:          registered occupancy 0..DEPTH
import spike_pkg::*;
module spike_event_fifo #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  spike_event_t  push_data,
    input  logic          pop,
    output spike_event_t  pop_data,
    output logic [CW-1:0] count
);
    logic [PW-1:0] wr_ptr, rd_ptr;
    spike_event_t  mem [DEPTH];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
    assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: round-robin merge of spike event channels onto the spike bus
//   clk, reset (async active-low)
//   in_valid/in_address/in_on_off/in_ready: per-channel valid/ready event sources
//   out_enable:  bus slot available this cycle
//   spike_out:   registered single-cycle event pulses to the synapses
//   fifo_level:  queued events; events_sent: wrapping count of emitted events
import spike_pkg::*;
module spike_event_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = spike_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH    = 16,
    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CHANNELS-1:0]      in_valid,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] in_address,
    input  logic [NUM_CHANNELS-1:0]      in_on_off,
    output logic [NUM_CHANNELS-1:0]      in_ready,
    input  logic                         out_enable,
    spike_if.master                      spike_out,
    output logic [LW-1:0]                fifo_level,
    output logic [CNT_WIDTH-1:0]         events_sent
);
    logic [PW-1:0]           rr_ptr, grant_idx;
    logic [NUM_CHANNELS-1:0] grant;
    logic                    found, push, pop, eligible;
    spike_event_t            entry, head;
    // First requester at or after rr_ptr, wrapping; depends only on in_valid.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (!found && in_valid[(int'(rr_ptr) + j) % NUM_CHANNELS]) begin
                grant[(int'(rr_ptr) + j) % NUM_CHANNELS] = 1'b1;
                grant_idx = PW'((int'(rr_ptr) + j) % NUM_CHANNELS);
                found     = 1'b1;
            end
        end
    end
    assign pop      = out_enable && (fifo_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign eligible = (fifo_level < LW'(FIFO_DEPTH)) || pop;
    assign in_ready = (reset && eligible) ? grant : '0;
    assign push     = |in_ready;
    assign entry.address = in_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign entry.on_off  = in_on_off[grant_idx];
    spike_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_level)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= '0;
            spike_out.valid   <= 1'b0;
            spike_out.address <= '0;
            spike_out.on_off  <= 1'b0;
            events_sent       <= '0;
        end else begin
            if (push) rr_ptr <= (grant_idx == PW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PW'(1);
            spike_out.valid <= pop;
            if (pop) begin
                spike_out.address <= head.address;
                spike_out.on_off  <= head.on_off;
                events_sent       <= events_sent + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_spike_event_arbiter.sv
// tb_spike_event_arbiter: directed self-checking bench for spike_event_arbiter
module tb_spike_event_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_address;
    logic [3:0]  in_on_off;
    logic [3:0]  in_ready;
    logic        out_enable;
    logic [3:0]  fifo_level;
    logic [15:0] events_sent;
    int total = 0;
    int bad = 0;
    spike_if intf ();
    spike_event_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_address  (in_address),
        .in_on_off   (in_on_off),
        .in_ready    (in_ready),
        .out_enable  (out_enable),
        .spike_out   (intf),
        .fifo_level  (fifo_level),
        .events_sent (events_sent)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    initial begin
        int acc, n, i;
        reset = 1'b0;
        in_valid = 4'hf;
        in_address = '0;
        in_on_off = '0;
        out_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", intf.valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_events", events_sent, 0);
        check("rst_ready", in_ready, 0);
        check("rst_addr", intf.address, 0);
        // single event on channel 2
        in_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        in_valid = 4'b0100;
        in_address[16 +: 8] = 8'h15;
        in_on_off = 4'b0100;
        #1 check("single_ready", in_ready, 4'b0100);
        @(negedge clk);
        in_valid = '0;
        check("single_nolat", intf.valid, 0);
        check("single_level", fifo_level, 1);
        @(negedge clk);
        check("single_valid", intf.valid, 1);
        check("single_addr", intf.address, 8'h15);
        check("single_onoff", intf.on_off, 1);
        check("single_events", events_sent, 1);
        @(negedge clk);
        check("single_pulse", intf.valid, 0);
        check("single_hold", intf.address, 8'h15);
        // round robin: rr_ptr is 3 after accepting channel 2
        for (int c = 0; c < 4; c++) in_address[c*8 +: 8] = 8'h10 + 8'(c);
        in_on_off = 4'b1010;
        in_valid = 4'hf;
        #1 check("rr_ready0", in_ready, 4'b1000);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            #1 check("rr_ready", in_ready, 32'(1) << ((3 + c) % 4));
            check("rr_level", fifo_level, 1);
            check("rr_events", events_sent, c);
            if (c >= 2) begin
                check("rr_valid", intf.valid, 1);
                check("rr_addr", intf.address, 8'h10 + 8'((3 + c - 2) % 4));
                check("rr_onoff", intf.on_off, ((3 + c - 2) % 4) & 1);
            end
        end
        @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);
        check("rr_drain_level", fifo_level, 0);
        check("rr_drain_events", events_sent, 9);
        // backpressure to full
        out_enable = 1'b0;
        in_valid = 4'hf;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            #1 if (in_ready != 0) acc++;
            @(negedge clk);
        end
        check("bp_accepts", acc, 8);
        check("bp_ready", in_ready, 0);
        check("bp_level", fifo_level, 8);
        check("bp_valid", intf.valid, 0);
        // full with simultaneous pop and push
        out_enable = 1'b1;
        #1 check("full_ready", in_ready, 4'b1000);
        @(negedge clk);
        out_enable = 1'b0;
        check("full_level", fifo_level, 8);
        check("full_valid", intf.valid, 1);
        check("full_addr", intf.address, 8'h13);
        check("full_onoff", intf.on_off, 1);
        check("full_events", events_sent, 10);
        @(negedge clk);
        check("full_pulse", intf.valid, 0);
        check("full_ready_off", in_ready, 0);
        in_valid = '0;
        out_enable = 1'b1;
        for (int m = 0; m < 8; m++) begin
            @(negedge clk);
            check("drain_valid", intf.valid, 1);
            check("drain_addr", intf.address, 8'h10 + 8'(m % 4));
        end
        check("drain_level", fifo_level, 0);
        check("drain_events", events_sent, 18);
        // wrap-around: 20 events through channel 1 with toggling out_enable
        out_enable = 1'b0;
        i = 0;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
            @(negedge clk);
            if (intf.valid) begin
                check("wrap_addr", intf.address, 8'h40 + 8'(n));
                check("wrap_onoff", intf.on_off, n & 1);
                n++;
            end
            in_valid = (i < 20) ? 4'b0010 : 4'b0000;
            in_address[8 +: 8] = 8'h40 + 8'(i);
            in_on_off = {2'b00, 1'(i & 1), 1'b0};
            out_enable = ~out_enable;
            #1 if (in_ready[1]) i++;
        end
        check("wrap_count", n, 20);
        check("wrap_events", events_sent, 38);
        // reset mid-stream with 5 queued
        in_valid = '0;
        out_enable = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 4'b0001;
        for (int cyc = 0; cyc < 20 && fifo_level != 5; cyc++) @(negedge clk);
        in_valid = '0;
        check("mid_level5", fifo_level, 5);
        reset = 1'b0;
        #1 check("mid_valid", intf.valid, 0);
        check("mid_level", fifo_level, 0);
        check("mid_events", events_sent, 0);
        @(negedge clk);
        reset = 1'b1;
        out_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_nostale", intf.valid, 0);
        in_valid = 4'b0011 & 4'b0010;
        in_address[8 +: 8] = 8'h77;
        in_on_off = 4'b0000;
        #1 check("mid_ready", in_ready, 4'b0010);
        @(negedge clk);
        in_valid = '0;
        check("mid_lat", intf.valid, 0);
        @(negedge clk);
        check("mid_new_valid", intf.valid, 1);
        check("mid_new_addr", intf.address, 8'h77);
        check("mid_new_onoff", intf.on_off, 0);
        check("mid_new_events", events_sent, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
